// File: rtl/rom_bus_bridge.sv
// CPU-bus front end for the synchronous ROM array: window decode, one-cycle ROM latency
// absorption, write protection. Optional macro ROM_WP_COUNT_EN enables the saturating wp_count.
module rom_bus_bridge #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ROM_AW     = 15,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hB000,
  parameter logic [ADDR_WIDTH-1:0] ROM_TOP    = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  rom_hit,
  output logic                  rom_cs,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  wp_err,
  output logic [7:0]            wp_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wp_err_q, wp_err_d;
  logic                  wp_block;

  // Compare one bit wider so a window ending at the top of the address space never wraps.
  assign rom_hit = ({1'b0, cpu_addr} >= {1'b0, ROM_BASE}) &&
                   ({1'b0, cpu_addr} <= {1'b0, ROM_TOP});

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    wp_err_d  = wp_err_q;
    wp_block  = 1'b0;
    rom_cs    = 1'b0;
    rom_addr  = '0;
    cpu_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && rom_hit) begin
          if (!cpu_we) begin
            // Gated by reset_n so a request present during reset never strobes the ROM.
            rom_cs   = reset_n;
            rom_addr = reset_n ? ROM_AW'(cpu_addr - ROM_BASE) : '0;
            state_d  = FETCH;
          end else begin
            wp_block = 1'b1;
            wp_err_d = 1'b1;
            state_d  = RESP;
          end
        end
      end
      FETCH: begin
        rdata_d = rom_data;
        state_d = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      wp_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      wp_err_q <= wp_err_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign wp_err    = wp_err_q;

`ifdef ROM_WP_COUNT_EN
  logic [7:0] wp_count_q, wp_count_d;

  always_comb begin
    wp_count_d = wp_count_q;
    if (wp_block && (wp_count_q != 8'hFF)) wp_count_d = wp_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) wp_count_q <= 8'd0;
    else          wp_count_q <= wp_count_d;
  end

  assign wp_count = wp_count_q;
`else
  assign wp_count = 8'd0;
`endif

endmodule

// File: doc/rom_bus_bridge.md
# rom_bus_bridge

Bus-side front end for the AIM65 synchronous ROM array. Decodes CPU accesses that fall in the ROM window, drives the ROM's chip-select and offset address, absorbs the ROM's one-cycle registered read latency, and returns registered read data with a one-cycle ready pulse. Writes into the window are blocked and acknowledged. Sits between the CPU bus controller (upstream) and the `rom` instance (downstream).

## Interface
Parameters:
- `ADDR_WIDTH`, 16: CPU address width.
- `DATA_WIDTH`, 8: data width; must match the ROM.
- `ROM_AW`, 15: ROM offset address width.
- `ROM_BASE`, 16'hB000: first CPU address of the ROM window, inclusive.
- `ROM_TOP`, 16'hFFFF: last CPU address of the ROM window, inclusive.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `cpu_req`  in  1: access request; held high until `cpu_ready`.
- `cpu_we`  in  1: 1 = write, 0 = read; qualified by `cpu_req`.
- `cpu_addr`  in  ADDR_WIDTH: CPU byte address.
- `cpu_rdata`  out  DATA_WIDTH: registered read data.
- `cpu_ready`  out  1: one-cycle completion pulse.
- `rom_hit`  out  1: combinational; `cpu_addr` lies within [ROM_BASE, ROM_TOP].
- `rom_cs`  out  1: ROM chip select, to `rom.cs`.
- `rom_addr`  out  ROM_AW: ROM offset, to `rom.addr`.
- `rom_data`  in  DATA_WIDTH: from `rom.data_out`; valid the cycle after `rom_cs`.
- `wp_err`  out  1: sticky write-protect violation flag.
- `wp_count`  out  8: violation counter (see Configuration).

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE:
  - `cpu_req & rom_hit & !cpu_we`: `rom_cs = 1` (combinational, this cycle only). `rom_addr = cpu_addr - ROM_BASE`, truncated to ROM_AW. Go to FETCH.
  - `cpu_req & rom_hit & cpu_we`: no `rom_cs`. Set `wp_err`, increment `wp_count`. Go to RESP with `cpu_rdata` unchanged.
  - `cpu_req & !rom_hit`: stay in IDLE with no response; another device serves the access.
- FETCH: `rom_data` is valid. Register it into `cpu_rdata`. Go to RESP.
- RESP: `cpu_ready = 1` for exactly this cycle. `cpu_req` is ignored. Go to IDLE.
- Address and `cpu_we` are sampled only in IDLE. Changes during FETCH/RESP do not affect the access in flight.
- `rom_cs` is 0 in every state other than the accepting IDLE cycle. `rom_addr` is 0 when `rom_cs` is 0.
- `wp_err` is cleared only by reset.
- Reset (any state, including mid-FETCH): state goes to IDLE. `cpu_rdata = 0`, `cpu_ready = 0`, `rom_cs = 0`, `rom_addr = 0`, `wp_err = 0`, `wp_count = 0`. A ROM word arriving the cycle after reset is discarded.

## Timing
- Read accepted at the edge ending cycle N:
  - `rom_cs` high during N.
  - `cpu_rdata` updates at the edge ending N+1.
  - `cpu_ready` high during N+2.
- Write or protected access accepted in cycle N: `cpu_ready` high during N+1.
- Earliest next acceptance is cycle N+3 for reads and N+2 for writes. Maximum read throughput is 1 per 3 cycles.
- `cpu_rdata` holds its value until the next completed read.
- Boundary addresses ROM_BASE and ROM_TOP are hits. ROM_BASE-1 is a miss. The address compare does not wrap.

## Configuration
- Macro `ROM_WP_COUNT_EN`.
- Defined: `wp_count` is an 8-bit counter that increments on each blocked write and saturates at 8'hFF. It does not wrap.
- Undefined: `wp_count` is tied to 0. `wp_err`, write blocking and write acknowledge are unchanged.

## Test plan
- Reset, then read 16'hE000 with ROM image byte 0x3000 = 8'hA9. Expect `rom_addr` = 15'h3000 with `rom_cs` high for exactly one cycle, `cpu_rdata` = 8'hA9, and `cpu_ready` high 2 cycles after acceptance.
- Boundary reads: 16'hB000 gives `rom_addr` 0. 16'hFFFF gives `rom_addr` 15'h4FFF. 16'hAFFF gives no `rom_cs` and no `cpu_ready`.
- Write 16'hC123: no `rom_cs`, `cpu_ready` one cycle later, `wp_err` = 1, `wp_count` = 1, `cpu_rdata` unchanged.
- 300 consecutive protected writes: `wp_count` = 8'hFF with `ROM_WP_COUNT_EN` defined and 0 without it. `wp_err` = 1 in both builds.
- Assert `reset_n` = 0 during FETCH: next cycle all outputs are 0 and there is no `cpu_ready`. A following read completes normally.
- Back-to-back reads with `cpu_req` held high: accept, `cpu_ready`, then the next accept in the cycle after RESP. Exactly one `cpu_ready` per access. Changing `cpu_addr` during FETCH does not alter the returned data.
